alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// Each accepted operation takes a single EXEC cycle, then is held in RESP
// until the consumer takes it. Illegal opcodes (6, 7) go straight to RESP
// with an error response. Round-robin or fixed (requester 0) priority.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   rN_valid/rN_a/rN_b/rN_op   requester N operation (N = 0,1)
//   rN_ready                   one-cycle accept strobe to requester N
//   alu_a/alu_b/alu_op         operands/opcode driven to the shared ALU
//   alu_result/alu_flags       combinational ALU outputs ({V,N,C,Z})
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_result/rsp_flags/rsp_err  response payload
//   busy                       high whenever not idle
//   op_cnt                     completed responses, wrapping
module alu_arbiter #(
  parameter int unsigned RR_EN   = 1,
  parameter int unsigned RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_valid,
  input  logic [7:0]  r0_a,
  input  logic [7:0]  r0_b,
  input  logic [2:0]  r0_op,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [7:0]  r1_a,
  input  logic [7:0]  r1_b,
  input  logic [2:0]  r1_op,
  output logic        r1_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] op_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // The pointer holds the last-served id; resetting it to the opposite of
  // RR_INIT makes RR_INIT the first winner under contention.
  localparam logic LAST_RST = (RR_INIT == 0) ? 1'b1 : 1'b0;
  localparam logic RR_ON    = (RR_EN != 0);

  logic [1:0]  r_state;
  logic        r_last;
  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic [2:0]  r_alu_op;
  logic        r_rsp_id;
  logic        r_rsp_err;
  logic [7:0]  r_rsp_result;
  logic [3:0]  r_rsp_flags;
  logic [15:0] r_op_cnt;

  logic        w_idle;
  logic        w_pick1;
  logic        w_accept;
  logic        w_illegal;
  logic [7:0]  w_sel_a;
  logic [7:0]  w_sel_b;
  logic [2:0]  w_sel_op;

  always_comb begin
    w_idle = (r_state == S_IDLE);
    if (r0_valid && r1_valid) begin
      w_pick1 = RR_ON & ~r_last;
    end else begin
      w_pick1 = r1_valid;
    end
    // rst_n gating keeps both strobes low while reset is held.
    w_accept  = w_idle & (r0_valid | r1_valid) & rst_n;
    w_sel_a   = w_pick1 ? r1_a  : r0_a;
    w_sel_b   = w_pick1 ? r1_b  : r0_b;
    w_sel_op  = w_pick1 ? r1_op : r0_op;
    w_illegal = w_sel_op[2] & w_sel_op[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= LAST_RST;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_op_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a  <= w_sel_a;
            r_alu_b  <= w_sel_b;
            r_alu_op <= w_sel_op;
            r_rsp_id <= w_pick1;
            if (w_illegal) begin
              r_rsp_err    <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_flags  <= '0;
              r_state      <= S_RESP;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_rsp_result <= alu_result;
          r_rsp_flags  <= alu_flags;
          r_rsp_err    <= 1'b0;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_op_cnt <= r_op_cnt + 16'd1;
            r_last   <= r_rsp_id;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign r0_ready   = w_accept & ~w_pick1;
  assign r1_ready   = w_accept & w_pick1;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign rsp_err    = r_rsp_err;
  assign busy       = (r_state != S_IDLE);
  assign op_cnt     = r_op_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance (RR_EN=1, RR_INIT=0) and a
// fixed-priority instance (RR_EN=0) share the requester stimulus. Each has
// its own behavioural ALU. Expected values come from constants and a
// transaction-level model of the arbiter.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       r0_valid, r1_valid, rsp_ready;
  logic [7:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0] r0_op, r1_op;

  logic        rr_r0_ready, rr_r1_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_busy;
  logic [7:0]  rr_alu_a, rr_alu_b, rr_alu_result, rr_rsp_result;
  logic [2:0]  rr_alu_op;
  logic [3:0]  rr_alu_flags, rr_rsp_flags;
  logic [15:0] rr_op_cnt;

  logic        fp_r0_ready, fp_r1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_err, fp_busy;
  logic [7:0]  fp_alu_a, fp_alu_b, fp_alu_result, fp_rsp_result;
  logic [2:0]  fp_alu_op;
  logic [3:0]  fp_alu_flags, fp_rsp_flags;
  logic [15:0] fp_op_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Shared ALU behaviour: returns {V,N,C,Z, result}. C on sub is borrow.
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    int ua, ub, sa, sb, r;
    logic v, c;
    logic [7:0] res;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    v = 1'b0; c = 1'b0; r = 0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sb) ? 1 : 0;
      default: r = 0;
    endcase
    res = r[7:0];
    return {v, res[7], c, (res == 8'h00), res};
  endfunction

  assign {rr_alu_flags, rr_alu_result} = alu_ref(rr_alu_a, rr_alu_b, rr_alu_op);
  assign {fp_alu_flags, fp_alu_result} = alu_ref(fp_alu_a, fp_alu_b, fp_alu_op);

  alu_arbiter #(.RR_EN(1), .RR_INIT(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_ready(rr_r0_ready),
    .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_ready(rr_r1_ready),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_op(rr_alu_op),
    .alu_result(rr_alu_result), .alu_flags(rr_alu_flags),
    .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id),
    .rsp_result(rr_rsp_result), .rsp_flags(rr_rsp_flags), .rsp_err(rr_rsp_err),
    .busy(rr_busy), .op_cnt(rr_op_cnt)
  );

  alu_arbiter #(.RR_EN(0), .RR_INIT(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_ready(fp_r0_ready),
    .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_ready(fp_r1_ready),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op),
    .alu_result(fp_alu_result), .alu_flags(fp_alu_flags),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_result(fp_rsp_result), .rsp_flags(fp_rsp_flags), .rsp_err(fp_rsp_err),
    .busy(fp_busy), .op_cnt(fp_op_cnt)
  );

  // Returns at a falling edge with reset just released and no requests.
  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_tests++;
    if ({rr_r0_ready, rr_r1_ready, rr_busy, rr_rsp_valid} !== 4'b0000) begin
      $display("FAIL reset_ctrl: got %b exp 0000", {rr_r0_ready, rr_r1_ready, rr_busy, rr_rsp_valid}); n_fail++;
    end
    n_tests++;
    if ({rr_rsp_id, rr_rsp_err, rr_rsp_flags, rr_rsp_result} !== 14'h0) begin
      $display("FAIL reset_rsp: got %h exp 0", {rr_rsp_id, rr_rsp_err, rr_rsp_flags, rr_rsp_result}); n_fail++;
    end
    n_tests++;
    if ({rr_alu_a, rr_alu_b, rr_alu_op, rr_op_cnt} !== 35'h0) begin
      $display("FAIL reset_alu_cnt: got %h exp 0", {rr_alu_a, rr_alu_b, rr_alu_op, rr_op_cnt}); n_fail++;
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if ({rr_r0_ready, rr_busy, fp_r0_ready, fp_busy} !== 4'b0000) begin
      $display("FAIL reset_held: got %b exp 0000", {rr_r0_ready, rr_busy, fp_r0_ready, fp_busy}); n_fail++;
    end
    // Release with r0 already requesting: offer now, accept on the first edge.
    r1_valid = 1'b0; r0_a = 8'h01; r0_b = 8'h02; r0_op = 3'd0; rsp_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({rr_r0_ready, rr_busy} !== 2'b10) begin
      $display("FAIL reset_first_offer: got %b exp 10", {rr_r0_ready, rr_busy}); n_fail++;
    end
    @(negedge clk);
    r0_valid = 1'b0;
    #1;
    n_tests++;
    if ({rr_busy, rr_alu_a, rr_alu_b} !== {1'b1, 8'h01, 8'h02}) begin
      $display("FAIL reset_first_accept: got %h exp 10102", {rr_busy, rr_alu_a, rr_alu_b}); n_fail++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_add;
    do_reset;
    r0_valid = 1'b1; r0_a = 8'h7F; r0_b = 8'h01; r0_op = 3'd0; rsp_ready = 1'b1;
    #1;
    n_tests++;
    if ({rr_r0_ready, rr_r1_ready} !== 2'b10) begin
      $display("FAIL add_grant: got %b exp 10", {rr_r0_ready, rr_r1_ready}); n_fail++;
    end
    @(negedge clk);
    r0_valid = 1'b0;
    #1;
    n_tests++;
    if ({rr_busy, rr_rsp_valid, rr_alu_a, rr_alu_b, rr_alu_op} !== {2'b10, 8'h7F, 8'h01, 3'd0}) begin
      $display("FAIL add_exec: got %h exp %h", {rr_busy, rr_rsp_valid, rr_alu_a, rr_alu_b, rr_alu_op},
               {2'b10, 8'h7F, 8'h01, 3'd0}); n_fail++;
    end
    @(negedge clk); #1;
    n_tests++;
    if ({rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_rsp_result, rr_rsp_flags} !== {3'b100, 8'h80, 4'b1100}) begin
      $display("FAIL add_rsp: got %h exp %h", {rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_rsp_result, rr_rsp_flags},
               {3'b100, 8'h80, 4'b1100}); n_fail++;
    end
    @(negedge clk); #1;
    n_tests++;
    if ({rr_busy, rr_rsp_valid, rr_op_cnt} !== {2'b00, 16'd1}) begin
      $display("FAIL add_done: got %h exp 00001", {rr_busy, rr_rsp_valid, rr_op_cnt}); n_fail++;
    end
    n_tests++;
    if ({rr_alu_a, rr_alu_b, rr_alu_op} !== {8'h7F, 8'h01, 3'd0}) begin
      $display("FAIL add_alu_hold: got %h exp %h", {rr_alu_a, rr_alu_b, rr_alu_op}, {8'h7F, 8'h01, 3'd0}); n_fail++;
    end
  endtask

  task automatic test_contention;
    bit exp_g[3] = '{1'b0, 1'b1, 1'b0};
    int ng = 0, nr = 0;
    do_reset;
    r0_valid = 1'b1; r0_a = 8'h05; r0_b = 8'h05; r0_op = 3'd1;
    r1_valid = 1'b1; r1_a = 8'h01; r1_b = 8'h02; r1_op = 3'd5;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && nr < 3; cyc++) begin
      #1;
      n_tests++;
      if (rr_r0_ready && rr_r1_ready) begin
        $display("FAIL rr_both_ready: got 11 exp not 11 at cycle %0d", cyc); n_fail++;
      end
      if ((rr_r0_ready || rr_r1_ready) && ng < 3) begin
        n_tests++;
        if (rr_r1_ready !== exp_g[ng]) begin
          $display("FAIL rr_grant_order: grant %0d got r%0d exp r%0d", ng, rr_r1_ready, exp_g[ng]); n_fail++;
        end
        ng++;
      end
      if (rr_rsp_valid) begin
        n_tests++;
        if ({rr_rsp_id, rr_rsp_err, rr_rsp_result, rr_rsp_flags} !==
            (exp_g[nr] ? {2'b10, 8'h01, 4'b0000} : {2'b00, 8'h00, 4'b0001})) begin
          $display("FAIL rr_rsp: resp %0d got %h", nr, {rr_rsp_id, rr_rsp_err, rr_rsp_result, rr_rsp_flags}); n_fail++;
        end
        nr++;
      end
      @(negedge clk);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    n_tests++;
    if (nr != 3 || ng != 3) begin
      $display("FAIL rr_timeout: got %0d grants %0d responses exp 3 3", ng, nr); n_fail++;
    end
  endtask

  task automatic test_fixed;
    int g0 = 0;
    do_reset;
    r0_valid = 1'b1; r0_a = 8'h11; r0_b = 8'h22; r0_op = 3'd0;
    r1_valid = 1'b1; r1_a = 8'h0F; r1_b = 8'hF0; r1_op = 3'd3;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      #1;
      n_tests++;
      if (fp_r1_ready !== 1'b0) begin
        $display("FAIL fp_r1_ready: got %b exp 0 at cycle %0d", fp_r1_ready, cyc); n_fail++;
      end
      if (fp_r0_ready) g0++;
      @(negedge clk);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    n_tests++;
    if (g0 != 5) begin
      $display("FAIL fp_r0_grants: got %0d exp 5", g0); n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    r0_valid = 1'b1; r0_a = 8'h3C; r0_b = 8'h0F; r0_op = 3'd4; rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      n_tests++;
      if ({rr_r0_ready, rr_rsp_valid} !== {cyc % 3 == 0, cyc % 3 == 2}) begin
        $display("FAIL b2b_timing: cycle %0d got %b exp %b", cyc, {rr_r0_ready, rr_rsp_valid},
                 {cyc % 3 == 0, cyc % 3 == 2}); n_fail++;
      end
      @(negedge clk);
    end
    r0_valid = 1'b0;
    #1;
    n_tests++;
    if (rr_op_cnt !== 16'd4) begin
      $display("FAIL b2b_cnt: got %0d exp 4", rr_op_cnt); n_fail++;
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    r1_valid = 1'b1; r1_a = 8'hF0; r1_b = 8'h3C; r1_op = 3'd2; rsp_ready = 1'b0;
    #1;
    n_tests++;
    if ({rr_r0_ready, rr_r1_ready} !== 2'b01) begin
      $display("FAIL bp_grant: got %b exp 01", {rr_r0_ready, rr_r1_ready}); n_fail++;
    end
    @(negedge clk);
    r0_valid = 1'b1; r0_op = 3'd0; r1_a = 8'h99;
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({rr_rsp_valid, rr_busy, rr_r0_ready, rr_r1_ready} !== 4'b1100) begin
        $display("FAIL bp_ctrl: cycle %0d got %b exp 1100", i, {rr_rsp_valid, rr_busy, rr_r0_ready, rr_r1_ready}); n_fail++;
      end
      n_tests++;
      if ({rr_rsp_id, rr_rsp_err, rr_rsp_result, rr_rsp_flags} !== {2'b10, 8'h30, 4'b0000}) begin
        $display("FAIL bp_payload: cycle %0d got %h exp %h", i, {rr_rsp_id, rr_rsp_err, rr_rsp_result, rr_rsp_flags},
                 {2'b10, 8'h30, 4'b0000}); n_fail++;
      end
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if ({rr_busy, rr_rsp_valid, rr_op_cnt} !== {2'b00, 16'd1}) begin
      $display("FAIL bp_release: got %h exp 00001", {rr_busy, rr_rsp_valid, rr_op_cnt}); n_fail++;
    end
  endtask

  task automatic test_illegal;
    do_reset;
    r1_valid = 1'b1; r1_a = 8'h55; r1_b = 8'hAA; r1_op = 3'd7; rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (rr_r1_ready !== 1'b1) begin
      $display("FAIL ill_grant: got %b exp 1", rr_r1_ready); n_fail++;
    end
    @(negedge clk);
    r1_valid = 1'b0;
    #1;
    n_tests++;
    if ({rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_rsp_result, rr_rsp_flags} !== {3'b111, 12'h000}) begin
      $display("FAIL ill_rsp: got %h exp 7000", {rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_rsp_result, rr_rsp_flags}); n_fail++;
    end
    @(negedge clk); #1;
    n_tests++;
    if ({rr_busy, rr_op_cnt} !== {1'b0, 16'd1}) begin
      $display("FAIL ill_cnt: got %h exp 00001", {rr_busy, rr_op_cnt}); n_fail++;
    end
  endtask

  // Transaction-level model: an accepted op is answered after 2 cycles
  // (1 if illegal) and stays presented until rsp_ready is sampled high.
  task automatic test_random;
    bit act = 1'b0, served = 1'b0, last = 1'b0, win = 1'b0, any = 1'b0;
    int age = 0, lat = 0, cnt = 0;
    logic [7:0] la = '0, lb = '0;
    logic [2:0] lop = '0;
    logic lid = 1'b0, exp_err = 1'b0;
    logic [11:0] exp_rsp = '0;
    do_reset;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r0_valid = ($urandom_range(0, 9) < 6); r1_valid = ($urandom_range(0, 9) < 6);
      r0_a = 8'($urandom); r0_b = 8'($urandom); r1_a = 8'($urandom); r1_b = 8'($urandom);
      r0_op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      r1_op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      any = r0_valid || r1_valid;
      win = (r0_valid && r1_valid) ? (served ? !last : 1'b0) : r1_valid;
      n_tests++;
      if (!act) begin
        if ({rr_r0_ready, rr_r1_ready, rr_busy, rr_rsp_valid} !== {any && !win, any && win, 2'b00}) begin
          $display("FAIL rnd_idle: cycle %0d got %b exp %b", cyc, {rr_r0_ready, rr_r1_ready, rr_busy, rr_rsp_valid},
                   {any && !win, any && win, 2'b00}); n_fail++;
        end
      end else if (age < lat) begin
        if ({rr_r0_ready, rr_r1_ready, rr_busy, rr_rsp_valid, rr_alu_a, rr_alu_b, rr_alu_op} !== {4'b0010, la, lb, lop}) begin
          $display("FAIL rnd_exec: cycle %0d got %h exp %h", cyc,
                   {rr_r0_ready, rr_r1_ready, rr_busy, rr_rsp_valid, rr_alu_a, rr_alu_b, rr_alu_op}, {4'b0010, la, lb, lop}); n_fail++;
        end
      end else begin
        if ({rr_r0_ready, rr_r1_ready, rr_busy, rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_rsp_result, rr_rsp_flags} !==
            {4'b0011, lid, exp_err, exp_rsp[7:0], exp_rsp[11:8]}) begin
          $display("FAIL rnd_resp: cycle %0d got %h exp %h", cyc,
                   {rr_r0_ready, rr_r1_ready, rr_busy, rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_rsp_result, rr_rsp_flags},
                   {4'b0011, lid, exp_err, exp_rsp[7:0], exp_rsp[11:8]}); n_fail++;
        end
      end
      n_tests++;
      if (rr_op_cnt !== cnt[15:0]) begin
        $display("FAIL rnd_cnt: cycle %0d got %0d exp %0d", cyc, rr_op_cnt, cnt); n_fail++;
      end
      if (!act) begin
        if (any) begin
          act = 1'b1; age = 1; lid = win;
          la = win ? r1_a : r0_a; lb = win ? r1_b : r0_b; lop = win ? r1_op : r0_op;
          if (lop >= 3'd6) begin lat = 1; exp_err = 1'b1; exp_rsp = '0; end
          else begin lat = 2; exp_err = 1'b0; exp_rsp = alu_ref(la, lb, lop); end
        end
      end else if (age >= lat && rsp_ready) begin
        act = 1'b0; cnt++; served = 1'b1; last = lid;
      end else begin
        age++;
      end
      @(negedge clk);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic test_counter;
    do_reset;
    // Reset during EXEC abandons the operation.
    r0_valid = 1'b1; r0_a = 8'h03; r0_b = 8'h04; r0_op = 3'd0; rsp_ready = 1'b1;
    @(negedge clk);
    r0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rr_busy, rr_rsp_valid, rr_alu_a, rr_op_cnt} !== 26'h0) begin
      $display("FAIL rst_exec: got %h exp 0", {rr_busy, rr_rsp_valid, rr_alu_a, rr_op_cnt}); n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if ({rr_rsp_valid, rr_busy, rr_op_cnt} !== 18'h0) begin
        $display("FAIL rst_exec_after: cycle %0d got %h exp 0", i, {rr_rsp_valid, rr_busy, rr_op_cnt}); n_fail++;
      end
      @(negedge clk);
    end
    // Wrap: preload near the top and complete two illegal ops.
    force dut_rr.r_op_cnt = 16'hFFFE;
    #1;
    release dut_rr.r_op_cnt;
    #1;
    n_tests++;
    if (rr_op_cnt !== 16'hFFFE) begin
      $display("FAIL cnt_preload: got %h exp fffe", rr_op_cnt); n_fail++;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      r0_valid = 1'b1; r0_op = 3'd6; rsp_ready = 1'b1;
      @(negedge clk);
      r0_valid = 1'b0;
      @(negedge clk); #1;
      n_tests++;
      if (rr_op_cnt !== ((k == 0) ? 16'hFFFF : 16'h0000)) begin
        $display("FAIL cnt_wrap: step %0d got %h exp %h", k, rr_op_cnt, (k == 0) ? 16'hFFFF : 16'h0000); n_fail++;
      end
    end
    // Reset during RESP with the counter at 0xFFFF.
    force dut_rr.r_op_cnt = 16'hFFFF;
    #1;
    release dut_rr.r_op_cnt;
    @(negedge clk);
    r1_valid = 1'b1; r1_op = 3'd7; rsp_ready = 1'b0;
    @(negedge clk);
    r1_valid = 1'b0;
    #1;
    n_tests++;
    if ({rr_rsp_valid, rr_rsp_err, rr_op_cnt} !== {2'b11, 16'hFFFF}) begin
      $display("FAIL rst_resp_pre: got %h exp 3ffff", {rr_rsp_valid, rr_rsp_err, rr_op_cnt}); n_fail++;
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rr_rsp_valid, rr_busy, rr_r0_ready, rr_r1_ready, rr_rsp_id, rr_rsp_err, rr_rsp_result, rr_rsp_flags,
         rr_alu_a, rr_alu_b, rr_alu_op, rr_op_cnt} !== '0) begin
      $display("FAIL rst_resp: got %h exp 0", {rr_rsp_valid, rr_busy, rr_r0_ready, rr_r1_ready, rr_rsp_id, rr_rsp_err,
               rr_rsp_result, rr_rsp_flags, rr_alu_a, rr_alu_b, rr_alu_op, rr_op_cnt}); n_fail++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if ({rr_rsp_valid, rr_busy, rr_op_cnt} !== 18'h0) begin
      $display("FAIL rst_resp_after: got %h exp 0", {rr_rsp_valid, rr_busy, rr_op_cnt}); n_fail++;
    end
  endtask

  initial begin
    rst_n = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
    r0_a = '0; r0_b = '0; r0_op = '0; r1_a = '0; r1_b = '0; r1_op = '0;
    #2;
    test_reset;
    test_single_add;
    test_contention;
    test_fixed;
    test_back_to_back;
    test_backpressure;
    test_illegal;
    test_random;
    test_counter;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
